// File: rtl/reflet_mem_ctrl_pkg.sv
// Shared constants for the Reflet memory controller: opcodes, FSM encoding,
// access-size codes and opcode classification helpers.
package reflet_mem_ctrl_pkg;

    localparam logic [7:0] inst_pop  = 8'h03;
    localparam logic [7:0] inst_push = 8'h04;
    localparam logic [7:0] inst_call = 8'h05;
    localparam logic [7:0] inst_ret  = 8'h06;
    localparam logic [3:0] opp_str   = 4'hE;
    localparam logic [3:0] opp_load  = 4'hF;
    localparam logic [3:0] pc_id     = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    localparam logic [1:0] RB_WORD = 2'd0;
    localparam logic [1:0] RB_8    = 2'd1;
    localparam logic [1:0] RB_16   = 2'd2;
    localparam logic [1:0] RB_32   = 2'd3;

    function automatic logic op_is_stack(input logic [7:0] op);
        return (op == inst_pop) || (op == inst_push) || (op == inst_call) || (op == inst_ret);
    endfunction

    function automatic logic op_is_mem(input logic [7:0] op);
        return op_is_stack(op) || (op[7:4] == opp_str) || (op[7:4] == opp_load);
    endfunction

    function automatic logic op_is_write(input logic [7:0] op);
        return (op == inst_push) || (op == inst_call) || (op[7:4] == opp_str);
    endfunction

    // push and call pre-decrement the stack pointer by the access size
    function automatic logic op_is_predec(input logic [7:0] op);
        return (op == inst_push) || (op == inst_call);
    endfunction

    function automatic logic op_targets_pc(input logic [7:0] op);
        return (op == inst_call) || (op == inst_ret);
    endfunction

endpackage

// File: rtl/reflet_mem_lanes.sv
// Byte-lane datapath: size clip, address alignment, lane enables,
// write-data shift and read-data extraction.
module reflet_mem_lanes
    import reflet_mem_ctrl_pkg::*;
#(
    parameter int wordsize = 16,
    localparam int lanes = wordsize / 8
) (
    input  logic [wordsize-1:0] i_base,
    input  logic                i_predec,
    input  logic                i_byte_only,
    input  logic [1:0]          i_reduced_bits,
    input  logic [wordsize-1:0] i_wdata,
    input  logic [wordsize-1:0] i_rdata,
    output logic [wordsize-1:0] o_addr,
    output logic [lanes-1:0]    o_byte_en,
    output logic [wordsize-1:0] o_wdata,
    output logic [wordsize-1:0] o_rdata,
    output logic                o_misaligned
);

    localparam logic [3:0]          LANES4    = 4'(lanes);
    localparam logic [wordsize-1:0] ONE       = {{(wordsize-1){1'b0}}, 1'b1};
    localparam logic [wordsize-1:0] LANE_MASK = wordsize'(lanes - 1);

    logic [3:0]          w_n_raw;
    logic [3:0]          w_n;
    logic [wordsize-1:0] w_n_ws;
    logic [wordsize-1:0] w_size_mask;
    logic [wordsize-1:0] w_raw;
    logic [3:0]          w_off;
    logic [6:0]          w_shamt;
    logic [wordsize-1:0] w_byte_mask;

    // Decode the requested size in bytes before clipping to the bus width
    always_comb begin
        w_n_raw = LANES4;
        if (i_byte_only) begin
            w_n_raw = 4'd1;
        end else begin
            case (i_reduced_bits)
                RB_8:    w_n_raw = 4'd1;
                RB_16:   w_n_raw = 4'd2;
                RB_32:   w_n_raw = 4'd4;
                default: w_n_raw = LANES4;
            endcase
        end
    end

    assign w_n          = (w_n_raw > LANES4) ? LANES4 : w_n_raw;
    assign w_n_ws       = {{(wordsize-4){1'b0}}, w_n};
    assign w_size_mask  = w_n_ws - ONE;
    assign w_raw        = i_predec ? (i_base - w_n_ws) : i_base;
    assign o_addr       = w_raw & ~w_size_mask;
    assign o_misaligned = |(w_raw & w_size_mask);
    assign w_off        = 4'(o_addr & LANE_MASK);
    assign w_shamt      = {w_off, 3'b000};

    // Per-lane enables and the n-byte data mask; alignment keeps off+n within the bus
    always_comb begin
        w_byte_mask = {wordsize{1'b0}};
        o_byte_en   = {lanes{1'b0}};
        for (int i = 0; i < lanes; i++) begin
            w_byte_mask[8*i +: 8] = (4'(i) < w_n) ? 8'hFF : 8'h00;
            o_byte_en[i]          = (4'(i) >= w_off) && (4'(i) < (w_off + w_n));
        end
    end

    assign o_wdata = (i_wdata & w_byte_mask) << w_shamt;
    assign o_rdata = (i_rdata >> w_shamt) & w_byte_mask;

endmodule

// File: rtl/reflet_mem_ctrl.sv
// Reflet CPU-to-memory controller: instruction fetch, stack/load/store data
// phase over a req/ack handshake, and CPU stall generation.
module reflet_mem_ctrl
    import reflet_mem_ctrl_pkg::*;
#(
    parameter int wordsize = 16,
    localparam int lanes = wordsize / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic [wordsize-1:0] i_working_register,
    input  logic [wordsize-1:0] i_program_counter,
    input  logic [wordsize-1:0] i_stack_pointer,
    input  logic [wordsize-1:0] i_other_register,
    input  logic [1:0]          i_reduced_bits,
    output logic [7:0]          o_instruction,
    output logic [wordsize-1:0] o_out,
    output logic [3:0]          o_out_reg,
    output logic                o_ram_not_ready,
    output logic                o_misaligned,
    output logic [wordsize-1:0] o_addr,
    output logic [wordsize-1:0] o_data_out,
    output logic [lanes-1:0]    o_byte_en,
    output logic                o_write_en,
    output logic                o_mem_req,
    input  logic                i_mem_ack,
    input  logic [wordsize-1:0] i_data_in
);

    localparam logic [wordsize-1:0] ONE = {{(wordsize-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [7:0]          r_instruction;
    logic [wordsize-1:0] r_out;
    logic [3:0]          r_out_reg;

    logic                w_is_data;
    logic                w_req;
    logic                w_is_write;
    logic [wordsize-1:0] w_base;
    logic                w_predec;
    logic                w_byte_only;
    logic [wordsize-1:0] w_wdata;
    logic [wordsize-1:0] w_lane_addr;
    logic [lanes-1:0]    w_lane_be;
    logic [wordsize-1:0] w_lane_wdata;
    logic [wordsize-1:0] w_lane_rdata;
    logic                w_lane_mis;
    logic [7:0]          w_fetch_byte;

    assign w_is_data    = (r_state == ST_DATA);
    assign w_req        = (r_state == ST_FETCH) || w_is_data;
    assign w_is_write   = w_is_data && op_is_write(r_instruction);
    assign w_fetch_byte = w_lane_rdata[7:0];

    // Route the address base and write data for the current phase; the CPU is stalled so these are stable
    always_comb begin
        w_base      = i_program_counter;
        w_predec    = 1'b0;
        w_byte_only = 1'b1;
        w_wdata     = i_working_register;
        if (w_is_data) begin
            w_byte_only = 1'b0;
            w_base      = op_is_stack(r_instruction) ? i_stack_pointer : i_other_register;
            w_predec    = op_is_predec(r_instruction);
            w_wdata     = (r_instruction == inst_call) ? i_program_counter : i_working_register;
        end else begin
            w_byte_only = 1'b1;
        end
    end

    reflet_mem_lanes #(.wordsize(wordsize)) u_lanes (
        .i_base         (w_base),
        .i_predec       (w_predec),
        .i_byte_only    (w_byte_only),
        .i_reduced_bits (i_reduced_bits),
        .i_wdata        (w_wdata),
        .i_rdata        (i_data_in),
        .o_addr         (w_lane_addr),
        .o_byte_en      (w_lane_be),
        .o_wdata        (w_lane_wdata),
        .o_rdata        (w_lane_rdata),
        .o_misaligned   (w_lane_mis)
    );

    assign o_mem_req       = w_req;
    assign o_addr          = w_req ? w_lane_addr : {wordsize{1'b0}};
    assign o_byte_en       = w_req ? w_lane_be : {lanes{1'b0}};
    assign o_data_out      = w_is_write ? w_lane_wdata : {wordsize{1'b0}};
    assign o_write_en      = w_is_write;
    assign o_misaligned    = w_is_data && w_lane_mis;
    assign o_ram_not_ready = (r_state != ST_EXEC);
    assign o_instruction   = r_instruction;
    assign o_out           = r_out;
    assign o_out_reg       = r_out_reg;

    // Phase sequencing; a transfer completes only on an enabled edge with req and ack both high
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_instruction <= 8'h00;
            r_out         <= {wordsize{1'b0}};
            r_out_reg     <= 4'd0;
        end else if (i_enable) begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (i_mem_ack) begin
                        r_instruction <= w_fetch_byte;
                        r_out_reg     <= op_targets_pc(w_fetch_byte) ? pc_id : 4'd0;
                        if (op_is_mem(w_fetch_byte)) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_out   <= i_working_register;
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_mem_ack) begin
                        if (op_is_write(r_instruction)) begin
                            r_out <= i_working_register;
                        end else if (r_instruction == inst_ret) begin
                            r_out <= w_lane_rdata + ONE;
                        end else begin
                            r_out <= w_lane_rdata;
                        end
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: r_state <= ST_FETCH;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_mem_ctrl.sv
// Randomised self-checking bench for reflet_mem_ctrl at a 32-bit bus, with a
// byte-array RAM and a transaction-level expectation per instruction.
module tb_reflet_mem_ctrl;
    import reflet_mem_ctrl_pkg::*;

    localparam int WS = 32;
    localparam int LN = WS / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [WS-1:0] wr, pc, sp, oth;
    logic [1:0]    rb;
    logic [7:0]    instruction;
    logic [WS-1:0] out_v;
    logic [3:0]    out_reg;
    logic          rnr, misaligned, write_en, mem_req, mem_ack;
    logic [WS-1:0] addr, data_out, data_in;
    logic [LN-1:0] byte_en;

    logic [7:0] mem [0:4095];
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    reflet_mem_ctrl #(.wordsize(WS)) dut (
        .clk(clk), .reset(reset), .i_enable(enable),
        .i_working_register(wr), .i_program_counter(pc),
        .i_stack_pointer(sp), .i_other_register(oth), .i_reduced_bits(rb),
        .o_instruction(instruction), .o_out(out_v), .o_out_reg(out_reg),
        .o_ram_not_ready(rnr), .o_misaligned(misaligned), .o_addr(addr),
        .o_data_out(data_out), .o_byte_en(byte_en), .o_write_en(write_en),
        .o_mem_req(mem_req), .i_mem_ack(mem_ack), .i_data_in(data_in)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int b;
        b = int'(a & 32'h0000_0FFC);
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    function automatic int size_of(input logic [1:0] r);
        case (r)
            2'd1:    return 1;
            2'd2:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic mem_write_bus();
        int b;
        b = int'(addr & 32'h0000_0FFC);
        for (int i = 0; i < LN; i++)
            if (byte_en[i]) mem[b+i] = data_out[8*i +: 8];
    endtask

    // Runs one instruction; called on a falling edge whose following rising edge enters FETCH
    task automatic run_instr(input logic [7:0] op, input logic [31:0] t_pc, input logic [31:0] t_sp,
                             input logic [31:0] t_wr, input logic [31:0] t_oth, input logic [1:0] t_rb,
                             input int wf, input int wd, input bit use_dis);
        bit is_mem, is_wr, done;
        int n, phase, cnt, cyc, guard, exp_cyc, off;
        logic [31:0] raw, al, exp_rd, exp_out, exp_do, mask, wdat;
        logic [3:0] exp_be, exp_fbe;
        bit exp_mis, en;

        pc = t_pc; sp = t_sp; wr = t_wr; oth = t_oth; rb = t_rb;
        mem[int'(t_pc)] = op;

        is_mem = (op == inst_pop) || (op == inst_push) || (op == inst_call) || (op == inst_ret)
                 || (op[7:4] == opp_str) || (op[7:4] == opp_load);
        is_wr  = (op == inst_push) || (op == inst_call) || (op[7:4] == opp_str);
        n = size_of(t_rb);
        if (op == inst_push || op == inst_call) raw = t_sp - n;
        else if (op == inst_pop || op == inst_ret) raw = t_sp;
        else raw = t_oth;
        al      = (raw / n) * n;
        exp_mis = (raw % n) != 0;
        off     = int'(al % LN);
        exp_be  = 4'(((1 << n) - 1) << off);
        mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        wdat    = (op == inst_call) ? t_pc : t_wr;
        exp_do  = (wdat & mask) << (8 * off);
        exp_rd  = 32'd0;
        for (int k = 0; k < n; k++) exp_rd = exp_rd + (32'(mem[int'(al) + k]) << (8 * k));
        if (is_mem && !is_wr) exp_out = (op == inst_ret) ? exp_rd + 32'd1 : exp_rd;
        else exp_out = t_wr;
        exp_fbe = 4'b0001 << t_pc[1:0];
        exp_cyc = 2 + wf + (is_mem ? 1 + wd : 0);

        phase = 0; cnt = 0; cyc = 0; guard = 0; done = 0;
        while (!done && guard < 80) begin
            @(negedge clk);
            guard++;
            if (phase == 0) begin
                check_val("fetch_req", mem_req, 1);
                check_val("fetch_addr", addr, t_pc);
                check_val("fetch_be", byte_en, exp_fbe);
                check_val("fetch_we", write_en, 0);
                check_val("fetch_rnr", rnr, 1);
                check_val("fetch_mis", misaligned, 0);
            end else if (phase == 1) begin
                check_val("data_req", mem_req, 1);
                check_val("data_addr", addr, al);
                check_val("data_be", byte_en, exp_be);
                check_val("data_we", write_en, is_wr);
                check_val("data_mis", misaligned, exp_mis);
                check_val("data_rnr", rnr, 1);
                if (is_wr) check_val("data_out", data_out, exp_do);
            end else begin
                check_val("exec_req", mem_req, 0);
                check_val("exec_rnr", rnr, 0);
                check_val("exec_out", out_v, exp_out);
                check_val("exec_outreg", out_reg, (op == inst_call || op == inst_ret) ? pc_id : 4'd0);
                check_val("exec_instr", instruction, op);
            end
            en = use_dis ? ($urandom_range(0, 5) != 0) : 1'b1;
            enable = en;
            data_in = mem_req ? word_at(addr) : $urandom;
            if (!en) begin
                mem_ack = 1'($urandom_range(0, 1));
            end else begin
                cyc++;
                if (phase == 0) begin
                    mem_ack = (cnt >= wf);
                    if (mem_ack) begin phase = is_mem ? 1 : 2; cnt = 0; end
                    else cnt++;
                end else if (phase == 1) begin
                    mem_ack = (cnt >= wd);
                    if (mem_ack) begin
                        if (write_en) mem_write_bus();
                        phase = 2;
                    end else cnt++;
                end else begin
                    mem_ack = 1'($urandom_range(0, 1));
                    check_val("latency", cyc, exp_cyc);
                    done = 1;
                end
            end
        end
        if (!done) check_val("timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        reset = 1'b0; enable = 1'b1; mem_ack = 1'b1; data_in = 32'h0;
        wr = 32'h0; pc = 32'h0; sp = 32'h0; oth = 32'h0; rb = 2'd0;

        repeat (2) @(negedge clk);
        check_val("rst_instr", instruction, 0);
        check_val("rst_out", out_v, 0);
        check_val("rst_outreg", out_reg, 0);
        check_val("rst_addr", addr, 0);
        check_val("rst_dout", data_out, 0);
        check_val("rst_be", byte_en, 0);
        check_val("rst_we", write_en, 0);
        check_val("rst_req", mem_req, 0);
        check_val("rst_mis", misaligned, 0);
        check_val("rst_rnr", rnr, 1);

        reset = 1'b1; enable = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check_val("idle_hold_req", mem_req, 0);
        enable = 1'b1;

        // Directed cases first, then randomised traffic
        run_instr(8'h2A, 32'h10, 32'h0, 32'h1111_2222, 32'h0, 2'd0, 0, 0, 0);
        mem[32'h200] = 8'hDD; mem[32'h201] = 8'hCC; mem[32'h202] = 8'hBB; mem[32'h203] = 8'hAA;
        mem[32'h40] = 8'h40; mem[32'h41] = 8'h00;
        run_instr(inst_push, 32'h11, 32'h100, 32'hDEAD_BEEF, 32'h0, 2'd0, 0, 0, 0);
        run_instr(8'hF1, 32'h12, 32'h0, 32'h5555_5555, 32'h203, 2'd1, 0, 0, 0);
        run_instr(inst_ret, 32'h13, 32'h40, 32'h0, 32'h0, 2'd2, 0, 3, 0);
        run_instr(8'hE2, 32'h14, 32'h0, 32'h1234_ABCD, 32'h101, 2'd2, 0, 0, 0);
        run_instr(inst_call, 32'h15, 32'h20, 32'h0, 32'h0, 2'd0, 1, 1, 0);
        run_instr(inst_pop, 32'h16, 32'h1C, 32'h0, 32'h0, 2'd0, 0, 0, 0);

        for (int t = 0; t < 160; t++) begin
            logic [7:0] op;
            case ($urandom_range(0, 6))
                0: op = inst_pop;
                1: op = inst_push;
                2: op = inst_call;
                3: op = inst_ret;
                4: op = {opp_str, 4'($urandom)};
                5: op = {opp_load, 4'($urandom)};
                default: op = 8'($urandom_range(16, 223));
            endcase
            run_instr(op, 32'h300 + $urandom_range(0, 255), 32'h500 + $urandom_range(0, 511),
                      $urandom, 32'h800 + $urandom_range(0, 1023), 2'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1);
        end

        // Reset during a DATA wait, then an ack held while enable is low
        pc = 32'h20; oth = 32'h900; rb = 2'd0; mem[32'h20] = 8'hF0;
        @(negedge clk);
        enable = 1'b1; mem_ack = 1'b1; data_in = word_at(32'h20);
        @(negedge clk);
        check_val("rstdata_in_data", misaligned | (addr == 32'h900), 1);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rstdata_req_before", mem_req, 1);
        reset = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        check_val("rstdata_req_after", mem_req, 0);
        check_val("rstdata_rnr", rnr, 1);
        check_val("rstdata_instr", instruction, 0);
        pc = 32'h30; mem[32'h30] = 8'h77; wr = 32'hCAFE_0001;
        reset = 1'b1; enable = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        check_val("hold_fetch_addr", addr, 32'h30);
        enable = 1'b0; mem_ack = 1'b1; data_in = word_at(32'h30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("hold_req", mem_req, 1);
            check_val("hold_rnr", rnr, 1);
        end
        enable = 1'b1;
        @(negedge clk);
        check_val("hold_exec_rnr", rnr, 0);
        check_val("hold_exec_instr", instruction, 8'h77);
        check_val("hold_exec_out", out_v, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/reflet_mem_ctrl.md
# reflet_mem_ctrl

Parametrised successor to the Reflet CPU↔RAM interface. It fetches instructions and performs stack, load and store data accesses over a req/ack memory handshake with arbitrary wait states. It generates byte lanes for 8/16/32-bit reduced accesses on a byte-addressed bus of `wordsize` bits. It sits between the CPU register file/ALU and the RAM or bus fabric, and stalls the CPU through `ram_not_ready`.

## Interface
- `wordsize`, 16, data/address width; legal values 8, 16, 32, 64.
- `lanes`, `wordsize/8`, derived byte-lane count; not to be overridden.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `enable`  in  1  global advance; when low the FSM and all registers hold.
- `working_register`, `program_counter`, `stack_pointer`, `other_register`  in  wordsize  CPU register values.
- `reduced_bits`  in  2  access size: 0 = full word, 1 = 8-bit, 2 = 16-bit, 3 = 32-bit. Sizes are clipped to `lanes` bytes.
- `instruction`  out  8  last fetched opcode.
- `out`  out  wordsize  value for the CPU to write back.
- `out_reg`  out  4  target register: `pc_id` for call/ret, else 0.
- `ram_not_ready`  out  1  CPU stall; low only in EXEC.
- `misaligned`  out  1  high during a data phase whose address is not a multiple of the access size.
- `addr`  out  wordsize  byte address.
- `data_out`  out  wordsize  write data, lane-shifted.
- `byte_en`  out  lanes  active byte lanes.
- `write_en`  out  1  write qualifier.
- `mem_req`  out  1  request.
- `mem_ack`  in  1  memory completion.
- `data_in`  in  wordsize  read data.

## Operation
- States: IDLE, FETCH, DATA, EXEC.
- IDLE → FETCH on the first enabled cycle after reset.
- FETCH: `mem_req`=1, `addr`=`program_counter`, 1-byte read, `byte_en` = lane `pc mod lanes`.
  - On req&ack, `instruction` ← that lane's byte.
  - Next state is DATA if the fetched byte is pop, push, call, ret, str* or load*; otherwise EXEC.
- DATA: `mem_req`=1. Access size is n bytes; `off` = `addr mod lanes`.
  - push: addr = SP−n, write `working_register`.
  - call: addr = SP−n, write `program_counter`.
  - pop, ret: addr = SP, read.
  - str: addr = `other_register`, write `working_register`.
  - load: addr = `other_register`, read.
  - `byte_en` = ((1<<n)−1)<<off.
  - `data_out` = data<<(8·off), upper bytes masked to zero.
  - Read result = (`data_in`>>(8·off)) masked to n bytes, zero-extended, and registered on req&ack.
- Misaligned access (addr mod n ≠ 0): `misaligned`=1 for all of DATA. The access is performed at addr rounded down to a multiple of n; `addr` presents the rounded value.
- EXEC: `mem_req`=0, `ram_not_ready`=0 for exactly one enabled cycle, then FETCH.
  - `out` = read result for pop/load.
  - `out` = read result+1 for ret.
  - `out` = `working_register` for push/call/str and all non-memory opcodes.
  - The CPU updates SP/PC/registers in this cycle.
- `write_en` = `mem_req` & write-type access in DATA; never during FETCH.
- With wordsize=8, `reduced_bits` is ignored, n=1, and `byte_en`=1.

## Timing
- Reset values: state IDLE; `instruction`, `out`, `out_reg`, `addr`, `data_out`, `byte_en`, `write_en`, `mem_req`, `misaligned` all 0; `ram_not_ready`=1.
- Reset mid-transaction drops `mem_req` on the next edge. Memory must discard the request.
- Handshake:
  - While `mem_req`=1, all of `addr`, `data_out`, `byte_en` and `write_en` are stable.
  - Completion is the first edge with `mem_req`&`mem_ack`&`enable`.
  - `mem_ack` may be combinational (zero-wait). Ack while `mem_req`=0 is ignored.
  - Ack while `enable`=0 is not consumed; memory holds ack until it is sampled.
- Latency with zero-wait memory: non-memory instruction 2 cycles (FETCH, EXEC); memory instruction 3 cycles (FETCH, DATA, EXEC). Each memory wait cycle adds 1.
- Back-to-back: `mem_req` is low for at least the EXEC cycle between transactions.

## Structure
- Opcode constants (`inst_pop`, `inst_push`, `inst_call`, `inst_ret`, `opp_str`, `opp_load`, `pc_id`) come from the shared `reflet.vh`.
- Add the state encoding and the `reduced_bits` size codes to the same include.
- One combinational sub-module, `reflet_mem_lanes`, holds the size clip, offset, `byte_en`, write shift and read extract, parametrised by `wordsize`.

## Test plan
- wordsize=16, zero-wait RAM, PC=0x0010 holding a non-memory opcode → req at 0x0010, `byte_en`=01; `ram_not_ready` low on cycle 2; `instruction`=RAM[0x10].
- wordsize=32, push, SP=0x100, WR=0xDEADBEEF, `reduced_bits`=0 → write at 0xFC, `byte_en`=1111, `ram_not_ready` low on cycle 3.
- wordsize=32, load, `other_register`=0x203, `reduced_bits`=1, `data_in`=0xAABBCCDD → `byte_en`=1000, `out`=0x000000AA.
- wordsize=16, ret with RAM at SP = 0x0040, 3 ack wait cycles → `out`=0x0041, `out_reg`=`pc_id`, total 6 cycles.
- wordsize=32, str 16-bit to 0x101 → `misaligned`=1, addr=0x100, `byte_en`=0011.
- Reset asserted during DATA wait; `enable` low while ack is pending → `mem_req`=0 after the reset edge; the ack is consumed only once `enable` returns high.
